// File: rtl/led_sequencer.sv
// led_sequencer: CPU-programmable LED pattern engine (static, blink, rotate) with tick-based stepping.
module led_sequencer #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        we_leds_o,
  output logic [31:0] leds_data_o
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STEP} state_t;
  localparam logic [23:0] PRESC_MAX = 24'(TICK_DIV - 1);
  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] pattern_q, pattern_d;
  logic [15:0] period_q, period_d;
  logic [15:0] step_q, step_d;
  logic [23:0] presc_q, presc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        phase_q, phase_d;
  logic [15:0] work_q, work_d;
  logic        we_leds_q, we_leds_d;
  logic [15:0] leds_q, leds_d;
  logic        wr_ctrl, wr_pat, wr_per, pcnt_last;
  logic [15:0] eff_period, step_val;
  logic        unused_bits;
  assign unused_bits = ^data_i[31:16];
  assign wr_ctrl = we_i && addr_i == 2'd0;
  assign wr_pat = we_i && addr_i == 2'd1;
  assign wr_per = we_i && addr_i == 2'd2;
  assign eff_period = period_q == 16'd0 ? 16'd1 : period_q;
  assign pcnt_last = {1'b0, pcnt_q} + 17'd1 == {1'b0, eff_period};
  // BLINK shows PATTERN when the toggled phase returns to 0, i.e. the current phase is 1
  assign step_val = ctrl_q[1:0] == 2'd0 ? pattern_q :
                    ctrl_q[1:0] == 2'd1 ? (phase_q ? pattern_q : 16'h0000) :
                    ctrl_q[1:0] == 2'd2 ? {work_q[14:0], work_q[15]} :
                                          {work_q[0], work_q[15:1]};
  assign data_o = addr_i == 2'd0 ? {29'd0, ctrl_q} :
                  addr_i == 2'd1 ? {16'd0, pattern_q} :
                  addr_i == 2'd2 ? {16'd0, period_q} :
                                   {15'd0, state_q != IDLE, step_q};
  assign we_leds_o = we_leds_q;
  assign leds_data_o = {16'h0000, leds_q};
  always_comb begin
    state_d = state_q;
    ctrl_d = wr_ctrl ? data_i[2:0] : ctrl_q;
    pattern_d = wr_pat ? data_i[15:0] : pattern_q;
    period_d = wr_per ? data_i[15:0] : period_q;
    step_d = step_q;
    presc_d = presc_q;
    pcnt_d = pcnt_q;
    phase_d = phase_q;
    work_d = work_q;
    we_leds_d = 1'b0;
    leds_d = leds_q;
    case (state_q)
      IDLE: begin
        if (wr_pat) begin
          we_leds_d = 1'b1;
          leds_d = data_i[15:0];
        end
        if (wr_ctrl && data_i[2]) state_d = LOAD;
      end
      LOAD: begin
        work_d = pattern_q;
        phase_d = 1'b0;
        presc_d = '0;
        pcnt_d = '0;
        step_d = '0;
        we_leds_d = 1'b1;
        leds_d = pattern_q;
        state_d = WAIT;
      end
      WAIT: begin
        presc_d = presc_q == PRESC_MAX ? 24'd0 : presc_q + 24'd1;
        if (presc_q == PRESC_MAX) begin
          pcnt_d = pcnt_last ? 16'd0 : pcnt_q + 16'd1;
          state_d = pcnt_last ? STEP : WAIT;
        end
      end
      default: begin
        phase_d = ctrl_q[1:0] == 2'd1 ? ~phase_q : phase_q;
        work_d = step_val;
        we_leds_d = 1'b1;
        leds_d = step_val;
        step_d = step_q + 16'd1;
        state_d = WAIT;
      end
    endcase
    if (wr_per) begin
      presc_d = '0;
      pcnt_d = '0;
    end
    if (wr_ctrl && !data_i[2] && state_q != IDLE) begin
      state_d = IDLE;
      we_leds_d = 1'b1;
      leds_d = pattern_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      pattern_q <= '0;
      period_q <= 16'd1;
      step_q <= '0;
      presc_q <= '0;
      pcnt_q <= '0;
      phase_q <= 1'b0;
      work_q <= '0;
      we_leds_q <= 1'b0;
      leds_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      pattern_q <= pattern_d;
      period_q <= period_d;
      step_q <= step_d;
      presc_q <= presc_d;
      pcnt_q <= pcnt_d;
      phase_q <= phase_d;
      work_q <= work_d;
      we_leds_q <= we_leds_d;
      leds_q <= leds_d;
    end
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk_i cycles per tick (1 ms at 100 MHz); legal range 2..2^24.
REQ-002 Port clk_i  input  1  system clock; all logic rising-edge.
REQ-003 Port rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port we_i  input  1  CPU bus write strobe, one cycle per write.
REQ-005 Port addr_i  input  2  register select: 0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS.
REQ-006 Port data_i  input  32  CPU write data.
REQ-007 Port data_o  output  32  combinational readback of the register at addr_i.
REQ-008 Port we_leds_o  output  1  write strobe to the LED output register.
REQ-009 Port leds_data_o  output  32  data to the LED output register; bits [31:16] always 0.

Function
REQ-010 CTRL[1:0] = mode: 0 STATIC, 1 BLINK, 2 ROT_L, 3 ROT_R; CTRL[2] = enable; CTRL[31:3] write-ignored, read 0.
REQ-011 PATTERN[15:0] base pattern; PERIOD[15:0] ticks per step, value 0 treated as 1; upper bits write-ignored, read 0.
REQ-012 STATUS[15:0] = step counter, read-only, wraps 0xFFFF->0x0000; STATUS[16] = 1 when FSM not IDLE; writes to addr 3 ignored.
REQ-013 FSM states: IDLE, LOAD, WAIT, STEP.
REQ-014 IDLE: write to PATTERN at cycle N -> we_leds_o=1 at N+1 with leds_data_o = new pattern, single cycle.
REQ-015 IDLE -> LOAD on write to CTRL with data_i[2]=1.
REQ-016 LOAD (1 cycle): work register <= PATTERN, phase <= 0, prescaler and period counter <= 0, STATUS step <= 0, we_leds_o=1 with PATTERN; -> WAIT.
REQ-017 WAIT: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and period counter increments; when period counter reaches effective PERIOD -> STEP, period counter <= 0.
REQ-018 STEP (1 cycle): next work value by mode -- STATIC: PATTERN; BLINK: phase toggles, output PATTERN when phase=0 else 0x0000; ROT_L: {w[14:0],w[15]}; ROT_R: {w[0],w[15:1]}; we_leds_o=1 with new value; step +1; -> WAIT.
REQ-019 Step interval in WAIT/STEP = effective PERIOD x TICK_DIV + 1 cycles (first step after LOAD: same).
REQ-020 Write CTRL with enable=0 while not IDLE -> next cycle IDLE and we_leds_o=1 with current PATTERN (restore).
REQ-021 Write CTRL with enable=1 while running: mode latched immediately, work register and counters untouched; new mode applies at next STEP.
REQ-022 Write PERIOD while running: period counter and prescaler cleared same edge; new interval starts.
REQ-023 Write PATTERN while running: PATTERN updated; work register reloaded only in LOAD or by STATIC/BLINK step rule.
REQ-024 Write on the same edge as a STEP transition: STEP uses register values before the write.
REQ-025 we_leds_o is exactly one cycle per event, never asserted in WAIT or IDLE except per REQ-014/020.
REQ-026 leds_data_o holds last driven value when we_leds_o=0.

Reset
REQ-027 rst_i=1 on a clock edge: FSM IDLE, CTRL=0, PATTERN=0, PERIOD=1, step=0, prescaler/period counter/phase=0, work register=0.
REQ-028 During and first cycle after reset: we_leds_o=0, leds_data_o=0; reset overrides any simultaneous we_i.
REQ-029 Reset mid-run aborts without emitting a restore write.

Verification (TICK_DIV=4)
REQ-030 Reset, write PATTERN=0x00A5 in IDLE -> one cycle we_leds_o=1, leds_data_o=0x000000A5; STATUS[16]=0.
REQ-031 PATTERN=0x0001, PERIOD=2, CTRL=0x6 (ROT_L, en) -> LOAD drives 0x0001, then every 9 cycles 0x0002, 0x0004 ... 0x8000, 0x0001; STATUS step increments each.
REQ-032 PATTERN=0x00FF, PERIOD=0, CTRL=0x5 (BLINK) -> alternating 0x0000, 0x00FF every 5 cycles.
REQ-033 While running ROT_R, write CTRL=0x0 -> next cycle we_leds_o=1 with PATTERN, STATUS[16]=0, no further strobes.
REQ-034 Write PERIOD=3 mid-WAIT -> next strobe exactly 13 cycles after the write edge.
REQ-035 Assert rst_i mid-WAIT with STATUS=5 -> all registers per REQ-027, no strobe, STATUS reads 0.
